uc_issue_ctrl: RTL

//   Host-side controller in front of the BCP top: buffers initial unit-clause literals, then

---
 rtl/uc_issue_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uc_issue_ctrl.sv
// Unit-clause issue controller: buffers initial literals, issues one per engine-idle stall edge,
// drains the result stack into a FIFO, tracks conflict and processing cycles.
module uc_issue_ctrl #(
  parameter int LIT_W     = 8,
  parameter int UC_DEPTH  = 64,
  parameter int RES_DEPTH = 128,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [LIT_W-1:0] load_lit,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             start,
  input  logic             stall,
  input  logic             conflict,
  output logic [LIT_W-1:0] mem2uca,
  output logic             mem2uca_valid,
  output logic             mem2uca_done,
  input  logic             mstack_empty,
  input  logic [LIT_W-1:0] mstack_lit,
  output logic             mstack_pop,
  output logic [LIT_W-1:0] res_lit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             done,
  output logic             conflict_seen,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int UC_AW  = $clog2(UC_DEPTH);
  localparam int UC_CW  = $clog2(UC_DEPTH + 1);
  localparam int RES_AW = $clog2(RES_DEPTH);
  localparam int RES_CW = RES_AW + 1;
  localparam logic [UC_CW-1:0]  UC_MAX   = UC_CW'(UC_DEPTH);
  localparam logic [RES_CW-1:0] RES_FULL = RES_CW'(RES_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t state_r, next_state_s;

  logic [LIT_W-1:0]  uc_buf_r [UC_DEPTH];
  logic [UC_CW-1:0]  uc_cnt_r;
  logic [UC_CW-1:0]  issue_idx_r;
  logic              prev_stall_r;
  logic [LIT_W-1:0]  res_mem_r [RES_DEPTH];
  logic [RES_AW-1:0] wr_ptr_r;
  logic [RES_AW-1:0] rd_ptr_r;
  logic [RES_CW-1:0] fifo_cnt_r;

  logic stall_edge_s, issue_s, last_s, start_s, load_s, push_s, pop_s;

  assign stall_edge_s = stall && !prev_stall_r;
  // conflict beats a coincident stall edge, so nothing issues on that cycle
  assign issue_s  = (state_r == ST_ISSUE) && stall_edge_s && !conflict && !clear &&
                    (issue_idx_r < uc_cnt_r);
  assign last_s   = (issue_idx_r + UC_CW'(1)) == uc_cnt_r;
  assign start_s  = (state_r == ST_IDLE) && start && !clear;
  assign load_s   = load_valid && load_ready && !clear;
  assign push_s   = mstack_pop;
  assign pop_s    = res_valid && res_ready && !clear;

  assign mem2uca_done = mem2uca_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    if (clear) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) next_state_s = (uc_cnt_r != '0) ? ST_ISSUE : ST_FINISH;
          else       next_state_s = ST_IDLE;
        end
        ST_ISSUE: begin
          if (conflict)              next_state_s = ST_FINISH;
          else if (issue_s && last_s) next_state_s = ST_RUN;
          else                        next_state_s = ST_ISSUE;
        end
        ST_RUN: begin
          if (conflict || stall_edge_s) next_state_s = ST_FINISH;
          else                          next_state_s = ST_RUN;
        end
        ST_FINISH: next_state_s = ST_FINISH;
        default:   next_state_s = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs and handshakes
  always_comb begin
    busy       = (state_r == ST_ISSUE) || (state_r == ST_RUN);
    done       = (state_r == ST_FINISH);
    load_ready = (state_r == ST_IDLE) && (uc_cnt_r < UC_MAX);
    mstack_pop = !mstack_empty && (fifo_cnt_r != RES_FULL) && !clear;
    res_valid  = (fifo_cnt_r != '0);
    if (fifo_cnt_r != '0) res_lit = res_mem_r[rd_ptr_r];
    else                  res_lit = '0;
  end

  // Control registers: counters, issue strobe, conflict flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_stall_r  <= 1'b0;
      uc_cnt_r      <= '0;
      issue_idx_r   <= '0;
      mem2uca       <= '0;
      mem2uca_valid <= 1'b0;
      conflict_seen <= 1'b0;
      cycle_cnt     <= '0;
    end else begin
      prev_stall_r <= stall;
      if (clear) begin
        uc_cnt_r      <= '0;
        issue_idx_r   <= '0;
        mem2uca       <= '0;
        mem2uca_valid <= 1'b0;
        conflict_seen <= 1'b0;
        cycle_cnt     <= '0;
      end else begin
        if (load_s) uc_cnt_r <= uc_cnt_r + UC_CW'(1);
        else        uc_cnt_r <= uc_cnt_r;
        if (start_s)      issue_idx_r <= '0;
        else if (issue_s) issue_idx_r <= issue_idx_r + UC_CW'(1);
        else              issue_idx_r <= issue_idx_r;
        mem2uca_valid <= issue_s;
        mem2uca       <= issue_s ? uc_buf_r[issue_idx_r[UC_AW-1:0]] : '0;
        if (busy && conflict) conflict_seen <= 1'b1;
        else                  conflict_seen <= conflict_seen;
        if (start_s)                   cycle_cnt <= '0;
        else if (busy && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
        else                           cycle_cnt <= cycle_cnt;
      end
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else if (clear) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + RES_AW'(1);
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + RES_AW'(1);
      else        rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + RES_CW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - RES_CW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Storage arrays, no reset needed: occupancy counters gate every read
  always_ff @(posedge clk) begin
    if (load_s) uc_buf_r[uc_cnt_r[UC_AW-1:0]] <= load_lit;
    if (push_s) res_mem_r[wr_ptr_r] <= mstack_lit;
  end

endmodule
